// File: rtl/de_stage_ctrl.sv
// ============================================================================
// de_stage_ctrl
// ----------------------------------------------------------------------------
// Hazard and sequencing controller for the decode->execute pipeline register
// and the F/D stages around it. Produces stall, flush and forwarding selects so
// the D/E register only advances when the instruction in E can leave. A
// multicycle op (multiply) is held in E for exactly MUL_LAT cycles. The D/E
// register itself has no reset, so FlushE is driven high throughout reset to
// clear it.
//
// Optional feature: define DE_STALL_COUNT_EN to build the saturating stall
// performance counter on StallCycles. Without it, StallCycles is tied to 0.
//
// Parameters:
//   MUL_LAT  total cycles a multicycle op occupies E (1..16)
//   REG_W    register-specifier width
//
// Ports:
//   clk, reset                   clock (rising edge), async active-high reset
//   RsD, RtD                     sources of the instruction in D
//   RsE, RtE                     sources of the instruction in E
//   WriteRegE/M/W, RegWriteE/M/W destination specifiers / write enables
//   MemToRegE                    instruction in E is a load
//   MulStartE                    instruction in E is a multicycle op
//   PCSrcD                       taken branch/jump resolved in D
//   StallF, StallD, StallE       hold PC, F/D register, D/E register
//   FlushD, FlushE               clear F/D, D/E register contents
//   ForwardAE, ForwardBE         ALU operand select: 00 RF, 01 W, 10 M
//   MulBusy                      multicycle sequencer not idle
//   StallCycles                  stall performance counter
// ============================================================================
module de_stage_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int REG_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemToRegE,
    input  logic             MulStartE,
    input  logic             PCSrcD,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MulBusy,
    output logic [31:0]      StallCycles
);

    // Counter must hold MUL_LAT-2; keep at least one bit so MUL_LAT=1 builds.
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mulstall;
    logic             lwstall;

    // Forward select for one operand; M is newer than W and therefore wins.
    function automatic logic [1:0] fwd_sel(
        input logic             rw_m,
        input logic [REG_W-1:0] wr_m,
        input logic             rw_w,
        input logic [REG_W-1:0] wr_w,
        input logic [REG_W-1:0] src
    );
        logic [1:0] sel;
        if (rw_m && (wr_m != REG_ZERO) && (wr_m == src)) begin
            sel = 2'b10;
        end else if (rw_w && (wr_w != REG_ZERO) && (wr_w == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Operand forwarding muxes (combinational, unaffected by reset).
    always_comb begin
        ForwardAE = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RsE);
        ForwardBE = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RtE);
    end

    // Load-use hazard: a load in E feeds a source of the instruction in D.
    always_comb begin
        lwstall = MemToRegE && RegWriteE && (WriteRegE != REG_ZERO) &&
                  ((WriteRegE == RsD) || (WriteRegE == RtD));
    end

    // Multicycle sequencer state and remaining-stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sequencer next state. The start cycle already stalls, so BUSY only
    // needs MUL_LAT-2 further stall cycles before its non-stalling release.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mulstall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MulStartE && (MUL_LAT > 1)) begin
                    mulstall = 1'b1;
                    state_d  = ST_BUSY;
                    cnt_d    = CNT_INIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q != CNT_ZERO) begin
                    mulstall = 1'b1;
                    cnt_d    = cnt_q - CNT_ONE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Stall/flush priority. A mul stall freezes everything, which also
    // defers a pending load-use or branch because their sources are held.
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        MulBusy = 1'b0;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (mulstall) begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            MulBusy = (state_q == ST_BUSY);
        end else if (lwstall) begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            FlushE  = 1'b1;
            MulBusy = (state_q == ST_BUSY);
        end else begin
            FlushD  = PCSrcD;
            MulBusy = (state_q == ST_BUSY);
        end
    end

`ifdef DE_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles in which fetch was held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (StallF && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign StallCycles = stall_cnt_q;
`else
    assign StallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_de_stage_ctrl.sv
module tb_de_stage_ctrl;

    localparam int MUL_LAT = 4;
    localparam int REG_W   = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [REG_W-1:0] RsD = '0, RtD = '0, RsE = '0, RtE = '0;
    logic [REG_W-1:0] WriteRegE = '0, WriteRegM = '0, WriteRegW = '0;
    logic             RegWriteE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
    logic             MemToRegE = 1'b0, MulStartE = 1'b0, PCSrcD = 1'b0;
    logic             StallF, StallD, StallE, FlushD, FlushE, MulBusy;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [31:0]      StallCycles;

    always #5 clk = ~clk;

    de_stage_ctrl #(.MUL_LAT(MUL_LAT), .REG_W(REG_W)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MulStartE(MulStartE), .PCSrcD(PCSrcD),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MulBusy(MulBusy), .StallCycles(StallCycles)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [REG_W-1:0] src);
        if (RegWriteM && WriteRegM != 0 && WriteRegM == src) return 2'b10;
        if (RegWriteW && WriteRegW != 0 && WriteRegW == src) return 2'b01;
        return 2'b00;
    endfunction

    // Reference model: a mul occupies E from its start cycle through start+MUL_LAT-1
    // (the release cycle); it stalls on every occupied cycle except the release one.
    longint      cyc = 0;
    bit          m_active = 1'b0;
    longint      m_start = 0, m_leave = 0;
    logic [31:0] m_sc = 32'd0;
    bit          in_op, ms, lw;
    logic        e_sf, e_sd, e_se, e_fd, e_fe, e_busy;
    logic [31:0] e_sc;

    always @(negedge clk) begin
        if (chk_en) begin
            e_sf = 0; e_sd = 0; e_se = 0; e_fd = 0; e_fe = 0; e_busy = 0;
            if (reset) begin
                e_fd = 1; e_fe = 1;
                m_active = 0;
                m_sc = 32'd0;
            end else begin
                in_op = m_active && (cyc <= m_leave);
                if (!in_op && MulStartE && MUL_LAT > 1) begin
                    m_active = 1; m_start = cyc; m_leave = cyc + MUL_LAT - 1; in_op = 1;
                end
                ms     = in_op && (cyc < m_leave);
                e_busy = in_op && (cyc > m_start);
                lw = MemToRegE && RegWriteE && WriteRegE != 0 &&
                     (WriteRegE == RsD || WriteRegE == RtD);
                if (ms) begin e_sf = 1; e_sd = 1; e_se = 1; end
                else if (lw) begin e_sf = 1; e_sd = 1; e_fe = 1; end
                else e_fd = PCSrcD;
            end
`ifdef DE_STALL_COUNT_EN
            e_sc = m_sc;
`else
            e_sc = 32'd0;
`endif
            chk("m_StallF", {31'd0, StallF}, {31'd0, e_sf});
            chk("m_StallD", {31'd0, StallD}, {31'd0, e_sd});
            chk("m_StallE", {31'd0, StallE}, {31'd0, e_se});
            chk("m_FlushD", {31'd0, FlushD}, {31'd0, e_fd});
            chk("m_FlushE", {31'd0, FlushE}, {31'd0, e_fe});
            chk("m_MulBusy", {31'd0, MulBusy}, {31'd0, e_busy});
            chk("m_ForwardAE", {30'd0, ForwardAE}, {30'd0, ref_fwd(RsE)});
            chk("m_ForwardBE", {30'd0, ForwardBE}, {30'd0, ref_fwd(RtE)});
            chk("m_StallCycles", StallCycles, e_sc);
            if (!reset && e_sf && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
            cyc++;
        end
    end

    logic exp_st [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_bz [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_fd [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_sc;

    initial begin
`ifdef DE_STALL_COUNT_EN
        exp_sc = 32'd4;
`else
        exp_sc = 32'd0;
`endif
        chk_en = 1'b1;
        step();
        #2;
        chk("rst_FlushD", {31'd0, FlushD}, 32'd1);
        chk("rst_FlushE", {31'd0, FlushE}, 32'd1);
        chk("rst_StallF", {31'd0, StallF}, 32'd0);
        chk("rst_MulBusy", {31'd0, MulBusy}, 32'd0);
        step();
        reset = 1'b0;

        // Forwarding priority
        step();
        RegWriteM = 1; WriteRegM = 5'd8; RegWriteW = 1; WriteRegW = 5'd8; RsE = 5'd8; RtE = 5'd0;
        #1;
        chk("fwd_A_M", {30'd0, ForwardAE}, 32'd2);
        chk("fwd_B_zero", {30'd0, ForwardBE}, 32'd0);
        WriteRegM = 5'd0;
        #1;
        chk("fwd_A_W", {30'd0, ForwardAE}, 32'd1);
        step();
        RegWriteM = 0; RegWriteW = 0; WriteRegW = 0; RsE = 0;

        // Load-use with simultaneous branch: lwstall wins
        step();
        MemToRegE = 1; RegWriteE = 1; WriteRegE = 5'd9; RtD = 5'd9; PCSrcD = 1;
        #2;
        chk("lw_StallF", {31'd0, StallF}, 32'd1);
        chk("lw_StallD", {31'd0, StallD}, 32'd1);
        chk("lw_StallE", {31'd0, StallE}, 32'd0);
        chk("lw_FlushE", {31'd0, FlushE}, 32'd1);
        chk("lw_FlushD", {31'd0, FlushD}, 32'd0);
        step();
        MemToRegE = 0; RegWriteE = 0; WriteRegE = 0; PCSrcD = 0;
        #2;
        chk("bubble_StallF", {31'd0, StallF}, 32'd0);
        chk("bubble_FlushE", {31'd0, FlushE}, 32'd0);

        // Multiply with a branch held in D
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) begin MulStartE = 1; PCSrcD = 1; end
            #2;
            chk("mul_StallE", {31'd0, StallE}, {31'd0, exp_st[i]});
            chk("mul_MulBusy", {31'd0, MulBusy}, {31'd0, exp_bz[i]});
            chk("mul_FlushD", {31'd0, FlushD}, {31'd0, exp_fd[i]});
        end
        step();
        MulStartE = 0; PCSrcD = 0;
        #2;
        chk("mul_done_MulBusy", {31'd0, MulBusy}, 32'd0);
        chk("stall_count", StallCycles, exp_sc);

        // Reset in the middle of BUSY (count 1)
        step();
        MulStartE = 1;
        step();
        step();
        #2;
        reset = 1;
        #1;
        chk("rmid_FlushE", {31'd0, FlushE}, 32'd1);
        chk("rmid_FlushD", {31'd0, FlushD}, 32'd1);
        chk("rmid_MulBusy", {31'd0, MulBusy}, 32'd0);
        chk("rmid_StallE", {31'd0, StallE}, 32'd0);
        step();
        reset = 0; MulStartE = 0;
        #2;
        chk("rpost_StallE", {31'd0, StallE}, 32'd0);
        chk("rpost_MulBusy", {31'd0, MulBusy}, 32'd0);

        // Randomized phase, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            step();
            RsD = REG_W'($urandom_range(0, 3));
            RtD = REG_W'($urandom_range(0, 3));
            RsE = REG_W'($urandom_range(0, 3));
            RtE = REG_W'($urandom_range(0, 3));
            WriteRegE = REG_W'($urandom_range(0, 3));
            WriteRegM = REG_W'($urandom_range(0, 3));
            WriteRegW = REG_W'($urandom_range(0, 3));
            RegWriteE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemToRegE = ($urandom_range(0, 9) < 3);
            MulStartE = ($urandom_range(0, 9) < 2);
            PCSrcD    = ($urandom_range(0, 9) < 3);
            reset     = ($urandom_range(0, 99) == 0);
        end
        step();
        reset = 0;
        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
